// File: rtl/tns_encoder_pipe_if.sv
// Valid/ready bus between the TNS encoder pipeline and its source/sink.
// Carries code_ovf only when TNS_RANGE_CHK_EN is defined.

// Handshake: a word moves on a rising edge when valid & ready are both high.
// Valid never waits on ready, and while valid is high and ready is low,
// the payload is held stable by its producer.
interface tns_encoder_pipe_if #(
  parameter int NGRP = 2,
  parameter int DW   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     datain;
  logic              out_valid;
  logic              out_ready;
  logic [3*NGRP-1:0] codeout;
`ifdef TNS_RANGE_CHK_EN
  logic              code_ovf;

  modport master (
    output in_valid, datain, out_ready,
    input  in_ready, out_valid, codeout, code_ovf
  );
  modport slave (
    input  in_valid, datain, out_ready,
    output in_ready, out_valid, codeout, code_ovf
  );
`else
  modport master (
    output in_valid, datain, out_ready,
    input  in_ready, out_valid, codeout
  );
  modport slave (
    input  in_valid, datain, out_ready,
    output in_ready, out_valid, codeout
  );
`endif
endinterface

// File: rtl/tns_encoder_pipe.sv
// Pipelined TNS crosstalk-avoidance encoder, GPS groups resolved per stage, MSB group first.
// Optional TNS_RANGE_CHK_EN adds code_ovf and keeps overflowing words out of the history.

module tns_encoder_pipe #(
  parameter int NGRP = 2,
  parameter int DW   = 5,
  parameter int WW   = 5,
  parameter int GPS  = 1,
  parameter logic [3*NGRP*WW-1:0] WEIGHTS = {5'd10, 5'd5, 5'd5, 5'd2, 5'd1, 5'd1}
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hist_clr,
  tns_encoder_pipe_if.slave bus
);

  localparam int NSTG = (NGRP + GPS - 1) / GPS;
  localparam int CW   = 3 * NGRP;

  // pipeline state: stage s holds the word after its groups were resolved
  logic [NSTG-1:0] vld_q;
  logic [DW-1:0]   res_q  [NSTG];
  logic [CW-1:0]   code_q [NSTG];
  logic [NGRP-1:0] hist_q;

  // stage inputs and combinational results
  logic [NSTG-1:0] stg_in_vld;
  logic [DW-1:0]   stg_in_res  [NSTG];
  logic [CW-1:0]   stg_in_code [NSTG];
  logic [DW-1:0]   nxt_res  [NSTG];
  logic [CW-1:0]   nxt_code [NSTG];
  logic [NGRP-1:0] a_vec;
  logic [NGRP-1:0] upd_vec;

  logic [DW-1:0] r_t, wa_t, wb_t, wc_t;
  logic [CW-1:0] cw_t;
  logic          a_t, b_t, c_t;
  int            g_t;

  logic adv;

`ifdef TNS_RANGE_CHK_EN
  function automatic logic [31:0] weight_sum();
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 3 * NGRP; i++) acc = acc + 32'(WEIGHTS[i*WW +: WW]);
    return acc;
  endfunction

  localparam logic [31:0] WSUM = weight_sum();

  logic [NSTG-1:0] ovf_q;
  logic [NSTG-1:0] stg_in_ovf;
`endif

  assign adv           = bus.out_ready | ~vld_q[NSTG-1];
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.codeout   = code_q[NSTG-1];
`ifdef TNS_RANGE_CHK_EN
  // final residue is registered with the codeword, so this stays held like codeout
  assign bus.code_ovf  = ovf_q[NSTG-1] | (res_q[NSTG-1] != '0);
`endif

  always_comb begin
    stg_in_vld[0]  = bus.in_valid;
    stg_in_res[0]  = bus.datain;
    stg_in_code[0] = '0;
`ifdef TNS_RANGE_CHK_EN
    stg_in_ovf[0]  = (32'(bus.datain) > WSUM);
`endif
    for (int s = 1; s < NSTG; s++) begin
      stg_in_vld[s]  = vld_q[s-1];
      stg_in_res[s]  = res_q[s-1];
      stg_in_code[s] = code_q[s-1];
`ifdef TNS_RANGE_CHK_EN
      stg_in_ovf[s]  = ovf_q[s-1];
`endif
    end
  end

  always_comb begin
    a_vec   = '0;
    upd_vec = '0;
    r_t  = '0;
    cw_t = '0;
    wa_t = '0;
    wb_t = '0;
    wc_t = '0;
    a_t  = 1'b0;
    b_t  = 1'b0;
    c_t  = 1'b0;
    g_t  = 0;
    for (int s = 0; s < NSTG; s++) begin
      r_t  = stg_in_res[s];
      cw_t = stg_in_code[s];
      for (int k = 0; k < GPS; k++) begin
        g_t = NGRP - 1 - s * GPS - k;
        if (g_t >= 0) begin
          wa_t = '0;
          wb_t = '0;
          wc_t = '0;
          wa_t[WW-1:0] = WEIGHTS[WW*(3*g_t+2) +: WW];
          wb_t[WW-1:0] = WEIGHTS[WW*(3*g_t+1) +: WW];
          wc_t[WW-1:0] = WEIGHTS[WW*(3*g_t)   +: WW];
          // between A and A+C either leading bit is legal; repeat the last one
          if (r_t < wa_t)               a_t = 1'b0;
          else if (r_t >= wa_t + wc_t)  a_t = 1'b1;
          else                          a_t = hist_q[g_t];
          if (a_t) r_t = r_t - wa_t;
          b_t = (r_t >= wb_t);
          if (b_t) r_t = r_t - wb_t;
          c_t = (r_t >= wc_t);
          if (c_t) r_t = r_t - wc_t;
          cw_t[3*g_t +: 3] = {a_t, b_t, c_t};
          a_vec[g_t]   = a_t;
`ifdef TNS_RANGE_CHK_EN
          upd_vec[g_t] = stg_in_vld[s] & ~stg_in_ovf[s];
`else
          upd_vec[g_t] = stg_in_vld[s];
`endif
        end
      end
      nxt_res[s]  = r_t;
      nxt_code[s] = cw_t;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      hist_q <= '0;
      for (int s = 0; s < NSTG; s++) begin
        res_q[s]  <= '0;
        code_q[s] <= '0;
      end
`ifdef TNS_RANGE_CHK_EN
      ovf_q <= '0;
`endif
    end else begin
      if (adv) begin
        vld_q <= stg_in_vld;
        for (int s = 0; s < NSTG; s++) begin
          res_q[s]  <= nxt_res[s];
          code_q[s] <= nxt_code[s];
        end
`ifdef TNS_RANGE_CHK_EN
        ovf_q <= stg_in_ovf;
`endif
      end
      // clear beats a same-edge update
      for (int g = 0; g < NGRP; g++) begin
        if (hist_clr)                hist_q[g] <= 1'b0;
        else if (adv && upd_vec[g])  hist_q[g] <= a_vec[g];
      end
    end
  end

endmodule

// File: tb/tb_tns_encoder_pipe.sv
// Directed bench for tns_encoder_pipe at defaults (NGRP=2, GPS=1): queue scoreboard plus monitor.
// Covers code_ovf behaviour when TNS_RANGE_CHK_EN is defined.

module tb_tns_encoder_pipe;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic hist_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // {ovf, codeword}
  logic [6:0] exp_q[$];
  logic [6:0] mon_e;
  logic       stall_prev = 1'b0;
  logic [5:0] stall_code = '0;

  tns_encoder_pipe_if #(.NGRP(2), .DW(5)) bus ();

  tns_encoder_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .hist_clr (hist_clr),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [4:0] d, input logic [5:0] code, input logic ovf, input logic clr);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.datain   = d;
    hist_clr     = clr;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
`ifdef TNS_RANGE_CHK_EN
      exp_q.push_back({ovf, code});
`else
      exp_q.push_back({1'b0, code});
      if (ovf) $display("note: overflow word sent without range check");
`endif
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    hist_clr     = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_codeout"},   32'(bus.codeout),   32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
`ifdef TNS_RANGE_CHK_EN
    check({tag, "_code_ovf"},  32'(bus.code_ovf),  32'd0);
`endif
  endtask

  // monitor: inputs change at negedge, so sample 2 time units later
  always @(negedge clock) begin
    #2;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_codeout",   32'(bus.codeout),   32'(stall_code));
      end
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        stall_prev = 1'b1;
        stall_code = bus.codeout;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: actual=%b expected=none", bus.codeout);
        end else begin
          mon_e = exp_q.pop_front();
          check("codeout", 32'(bus.codeout), 32'(mon_e[5:0]));
`ifdef TNS_RANGE_CHK_EN
          check("code_ovf", 32'(bus.code_ovf), 32'(mon_e[6]));
`endif
        end
      end
    end
  end

  logic [5:0] stream_exp [5];

  initial begin
    stream_exp[0] = 6'b000_000;
    stream_exp[1] = 6'b000_010;
    stream_exp[2] = 6'b000_011;
    stream_exp[3] = 6'b000_110;
    stream_exp[4] = 6'b000_111;

    bus.in_valid  = 1'b0;
    bus.datain    = '0;
    bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_reset_state("reset");
    @(negedge clock);
    reset = 1'b0;

    // first word and its latency
    send(5'd12, 6'b011_011, 1'b0, 1'b0);
    #1 check("latency_early", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    #1 check("latency_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    drain();

    // out-of-range word, then probe whether it touched the history
`ifdef TNS_RANGE_CHK_EN
    send(5'd25, 6'b111_111, 1'b1, 1'b0);
    send(5'd12, 6'b011_011, 1'b0, 1'b0);
`else
    send(5'd25, 6'b111_111, 1'b0, 1'b0);
    send(5'd12, 6'b100_100, 1'b0, 1'b0);
`endif
    drain();

    send(5'd15, 6'b110_000, 1'b0, 1'b0);
    send(5'd12, 6'b100_011, 1'b0, 1'b0);
    drain();

    send(5'd4, 6'b000_111, 1'b0, 1'b0);
    send(5'd2, 6'b000_100, 1'b0, 1'b0);
    drain();

    send(5'd15, 6'b110_000, 1'b0, 1'b0);
    drain();
    hist_clr = 1'b1;
    @(negedge clock);
    hist_clr = 1'b0;
    send(5'd12, 6'b011_011, 1'b0, 1'b0);
    drain();

    // back-pressure for 3 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 5; i++) send(5'(i), stream_exp[i], 1'b0, 1'b0);
      end
      begin
        repeat (2) @(negedge clock);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    send(5'd24, 6'b111_111, 1'b0, 1'b0);
    send(5'd9,  6'b010_111, 1'b0, 1'b0);
    send(5'd10, 6'b011_000, 1'b0, 1'b0);
    send(5'd14, 6'b011_111, 1'b0, 1'b0);
    drain();

    // clear on the same edge as an a=1 update: clear must win
    send(5'd15, 6'b110_000, 1'b0, 1'b1);
    send(5'd12, 6'b011_011, 1'b0, 1'b0);
    drain();

    // reset with words in flight
    send(5'd15, 6'b110_000, 1'b0, 1'b0);
    send(5'd15, 6'b110_000, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    #1 check_reset_state("midreset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midreset_quiet", 32'(bus.out_valid), 32'd0);
    send(5'd12, 6'b011_011, 1'b0, 1'b0);
    drain();

    repeat (3) @(negedge clock);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
